// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
// The command struct carries a zero-extended word address so it is independent of MEM_AW.
package dmem_pkg;

  localparam int unsigned MEM_AW_DEF       = 6;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/dmem_starve_ctr.sv
// Counts consecutive cycles a pending DMA request has been denied, saturating at LIMIT.
// force_grant_o tells the arbiter the DMA side must win the current cycle.
module dmem_starve_ctr
  import dmem_pkg::*;
#(
  parameter int unsigned LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic dma_req_i,
  input  logic dma_gnt_i,
  output logic force_grant_o
);

  localparam int unsigned CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (dma_req_i && !dma_gnt_i) begin
      cnt_d = (cnt_q == LIMIT_C) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_grant_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port data RAM: CPU has priority, DMA is force-granted
// after STARVE_LIMIT denied cycles. Read data returns one cycle after the grant to its owner.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_AW       = MEM_AW_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [31:0]       dma_addr,
  input  logic [31:0]       dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [31:0]       dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  owner_t      rd_owner_q, rd_owner_d;
  logic [31:0] cpu_rdata_q, dma_rdata_q;
  logic        starve_force;
  logic        force_dma;
  mem_cmd_t    cmd;
  logic        addr_unused;

  dmem_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk           (clk),
    .reset         (reset),
    .dma_req_i     (dma_req),
    .dma_gnt_i     (dma_gnt),
    .force_grant_o (starve_force)
  );

  // Grants are gated by reset so nothing reaches the RAM while the block is held in reset.
  assign force_dma = starve_force & dma_req;
  assign cpu_gnt   = !reset & cpu_req & !force_dma;
  assign dma_gnt   = !reset & dma_req & (force_dma | !cpu_req);

  always_comb begin
    cmd = '0;
    if (cpu_gnt) begin
      cmd = '{we: cpu_we, addr: 32'(cpu_addr[MEM_AW+1:2]), wdata: cpu_wdata};
    end else if (dma_gnt) begin
      cmd = '{we: dma_we, addr: 32'(dma_addr[MEM_AW+1:2]), wdata: dma_wdata};
    end
  end

  assign mem_en    = cpu_gnt | dma_gnt;
  assign mem_we    = cmd.we;
  assign mem_addr  = cmd.addr[MEM_AW-1:0];
  assign mem_wdata = cmd.wdata;

  assign addr_unused = ^{cpu_addr[31:MEM_AW+2], cpu_addr[1:0],
                         dma_addr[31:MEM_AW+2], dma_addr[1:0],
                         cmd.addr[31:MEM_AW]};

  always_comb begin
    rd_owner_d = OWN_NONE;
    if (cpu_gnt && !cpu_we) begin
      rd_owner_d = OWN_CPU;
    end else if (dma_gnt && !dma_we) begin
      rd_owner_d = OWN_DMA;
    end
  end

  // A read still in flight when reset rises is dropped rather than delivered.
  assign cpu_rvalid = !reset && (rd_owner_q == OWN_CPU);
  assign dma_rvalid = !reset && (rd_owner_q == OWN_DMA);
  assign cpu_rdata  = reset ? '0 : (cpu_rvalid ? mem_rdata : cpu_rdata_q);
  assign dma_rdata  = reset ? '0 : (dma_rvalid ? mem_rdata : dma_rdata_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_owner_q  <= OWN_NONE;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      rd_owner_q  <= rd_owner_d;
      cpu_rdata_q <= cpu_rdata;
      dma_rdata_q <= dma_rdata;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory between two requesters: the ARM core's load/store port (CPU) and a secondary master (DMA: program loader / debug port).
- Sits between the processor top and the data RAM.
- CPU has fixed priority, bounded by an anti-starvation counter that forces a DMA grant.
- Issues one memory command per cycle and returns read data one cycle later to the owner of that access.

Parameters:
- MEM_AW, 6, word-address width of the data RAM (64 words).
- STARVE_LIMIT, 4, consecutive cycles a pending DMA request may be denied before it is force-granted.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request
- cpu_we  in  1  CPU write enable (1 = store)
- cpu_addr  in  32  CPU byte address
- cpu_wdata  in  32  CPU store data
- cpu_gnt  out  1  CPU access accepted this cycle
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  32  CPU read data
- dma_req  in  1  DMA access request
- dma_we  in  1  DMA write enable
- dma_addr  in  32  DMA byte address
- dma_wdata  in  32  DMA store data
- dma_gnt  out  1  DMA access accepted this cycle
- dma_rvalid  out  1  DMA read data valid
- dma_rdata  out  32  DMA read data
- mem_en  out  1  memory command strobe
- mem_we  out  1  memory write enable
- mem_addr  out  MEM_AW  memory word address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid one cycle after a read command

Behaviour:
- Single clock `clk`. Reset is synchronous and active-high on `reset`. All state updates on posedge `clk`.
- Grants are combinational in the request cycle:
  - At most one of cpu_gnt/dma_gnt is high per cycle.
  - Requesters hold req/we/addr/wdata stable until they see gnt.
- Arbitration:
  - If starve_cnt == STARVE_LIMIT and dma_req: grant DMA.
  - Else if cpu_req: grant CPU.
  - Else if dma_req: grant DMA.
- starve_cnt (width clog2(STARVE_LIMIT+1)):
  - Increments when dma_req && !dma_gnt.
  - Clears when dma_gnt or !dma_req.
  - Saturates at STARVE_LIMIT.
- Memory command:
  - mem_en = cpu_gnt | dma_gnt.
  - mem_we, mem_addr, mem_wdata are muxed from the granted requester.
  - mem_addr = addr[MEM_AW+1:2]; byte offset bits [1:0] and bits above MEM_AW+1 are ignored.
  - When idle, mem_we = 0 and mem_addr/mem_wdata = 0.
- Read response pipeline:
  - Register rd_owner ∈ {NONE, CPU, DMA}, loaded each cycle: granted read -> owner; write or no grant -> NONE.
  - Cycle N+1 after a read grant in cycle N: owner's rvalid = 1 and owner's rdata = mem_rdata.
  - The other requester's rvalid = 0 and its rdata holds its last value.
  - Writes produce no rvalid.
- Back-to-back reads: a new grant is allowed in the same cycle a previous read's rvalid is asserted. Full throughput is one access per cycle.
- Reset values:
  - cpu_gnt = dma_gnt = mem_en = mem_we = 0 while reset is high, regardless of req.
  - rd_owner = NONE, starve_cnt = 0, cpu_rvalid = dma_rvalid = 0, cpu_rdata = dma_rdata = 0.
- Reset mid-operation: a read granted in the cycle reset asserts, or pending from the prior cycle, produces no rvalid after reset.
- Simultaneous requests: CPU wins unless starvation forces DMA. After a forced DMA grant the counter is 0, so the CPU wins the next cycle.
- The CPU stall signal used by the core is !cpu_gnt & cpu_req. The core consumes it; it is not generated here.

Decomposition:
- Package dmem_pkg:
  - typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_t
  - default MEM_AW and STARVE_LIMIT constants
  - typedef struct mem_cmd_t {we, addr, wdata}
- One sub-module: dmem_starve_ctr, holding the saturating counter and the force flag.

Test Plan:
- CPU only: reset high 2 cycles, then CPU writes 7 to addr 100 -> same cycle cpu_gnt=1, mem_en=1, mem_we=1, mem_addr=25, mem_wdata=7; no rvalid next cycle.
- CPU read after write: CPU reads addr 100 -> next cycle cpu_rvalid=1, cpu_rdata=7, dma_rvalid=0.
- Contention: cpu_req held continuously, DMA reads addr 96 -> dma_gnt=0 for 4 cycles, forced dma_gnt on the 5th, mem_addr=24; CPU re-granted the following cycle.
- Interleaved reads: CPU reads word 1 (cycle N), DMA reads word 2 (cycle N+1) -> cpu_rvalid at N+1, dma_rvalid at N+2, each with correct data, never both high.
- Address masking: DMA writes 0x5A to addr 0xFFFF_0103 -> mem_addr=0 (word 0 after [7:2] slice, MEM_AW=6), byte bits ignored.
- Reset mid-read: CPU read granted in cycle N, reset asserted in cycle N+1 -> cpu_rvalid=0, rdata=0, starve_cnt=0, and no grant while reset is high.
